// File: rtl/prbs12_checker_if.sv
// prbs12_checker_if
// Groups the serial receive stream, the counter clear and the checker status
// outputs of prbs12_checker into one bundle.
//   master : drives bit_in, bit_valid, clear; observes the status outputs
//   slave  : the checker itself
// Ports carried:
//   bit_in, bit_valid  received serial bit and its qualifier
//   clear              synchronous clear of err_count / bit_count
//   locked             high while the checker is locked
//   bit_err            one-cycle pulse per counted mismatch
//   lock_lost          one-cycle pulse when lock is dropped
//   zero_stuck         history register is all zeros after fill
//   err_count          saturating mismatch count (CNT_W bits)
//   bit_count          saturating checked-bit count (CNT_W bits)
interface prbs12_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_in;
    logic             bit_valid;
    logic             clear;
    logic             locked;
    logic             bit_err;
    logic             lock_lost;
    logic             zero_stuck;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] bit_count;

    modport master (
        output bit_in, bit_valid, clear,
        input  locked, bit_err, lock_lost, zero_stuck, err_count, bit_count
    );

    modport slave (
        input  bit_in, bit_valid, clear,
        output locked, bit_err, lock_lost, zero_stuck, err_count, bit_count
    );
endinterface

// File: rtl/prbs12_checker.sv
// prbs12_checker
// Self-synchronising checker for the 12-bit PRBS stream of the lfsr1
// generator (taps 11, 8, 5, 0). Each valid bit is compared against the bit
// predicted from the last 12 received bits; lock is acquired automatically,
// errors are counted while locked and lock is dropped when errors get dense.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset (overrides everything)
//   chk    prbs12_checker_if slave: bit_in/bit_valid/clear in,
//          locked/bit_err/lock_lost/zero_stuck/err_count/bit_count out
//
// state  | meaning
// HUNT   | filling the history register, no comparisons
// SYNC   | counting consecutive correct predictions toward lock
// LOCKED | checking; counting errors and watching error density
module prbs12_checker #(
    parameter int LOCK_MATCHES = 24,
    parameter int WINDOW       = 64,
    parameter int UNLOCK_ERRS  = 8,
    parameter int CNT_W        = 16
) (
    input logic              clk,
    input logic              reset,
    prbs12_checker_if.slave  chk
);
    localparam int MC_W = $clog2(LOCK_MATCHES + 1);
    localparam int WC_W = $clog2(WINDOW + 1);
    localparam int WE_W = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t          state;
    logic [11:0]     h;
    logic [3:0]      fill;
    logic [MC_W-1:0] match_cnt;
    logic [WC_W-1:0] win_cnt;
    logic [WE_W-1:0] win_err;

    logic        pred;
    logic        mismatch;
    logic [11:0] h_next;
    logic        h_zero;
    logic        cnt_bit;
    logic        cnt_err;

    assign pred     = h[11] ^ h[8] ^ h[5] ^ h[0];
    assign mismatch = chk.bit_in != pred;
    // The received bit, not the predicted one, is shifted in so the checker
    // recovers by itself after errors.
    assign h_next   = {h[10:0], chk.bit_in};
    assign h_zero   = (h_next == 12'd0);
    assign cnt_bit  = chk.bit_valid && (state == LOCKED);
    assign cnt_err  = cnt_bit && mismatch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= HUNT;
            h              <= '0;
            fill           <= '0;
            match_cnt      <= '0;
            win_cnt        <= '0;
            win_err        <= '0;
            chk.locked     <= 1'b0;
            chk.bit_err    <= 1'b0;
            chk.lock_lost  <= 1'b0;
            chk.zero_stuck <= 1'b0;
            chk.err_count  <= '0;
            chk.bit_count  <= '0;
        end else begin
            chk.bit_err   <= 1'b0;
            chk.lock_lost <= 1'b0;

            if (chk.bit_valid) begin
                h <= h_next;
                case (state)
                    HUNT: begin
                        fill <= fill + 4'd1;
                        if (fill == 4'd11) begin
                            state          <= SYNC;
                            match_cnt      <= '0;
                            chk.zero_stuck <= h_zero;
                        end
                    end
                    SYNC: begin
                        chk.zero_stuck <= h_zero;
                        // An all-zero history trivially predicts itself, so
                        // it must never accumulate toward lock.
                        if (mismatch || h_zero) begin
                            match_cnt <= '0;
                        end else if (match_cnt == MC_W'(LOCK_MATCHES - 1)) begin
                            state      <= LOCKED;
                            chk.locked <= 1'b1;
                            match_cnt  <= '0;
                            win_cnt    <= '0;
                            win_err    <= '0;
                        end else begin
                            match_cnt <= match_cnt + MC_W'(1);
                        end
                    end
                    LOCKED: begin
                        chk.zero_stuck <= h_zero;
                        chk.bit_err    <= mismatch;
                        if ((mismatch && (win_err == WE_W'(UNLOCK_ERRS - 1))) || h_zero) begin
                            state         <= SYNC;
                            chk.locked    <= 1'b0;
                            chk.lock_lost <= 1'b1;
                            match_cnt     <= '0;
                        end else if (win_cnt == WC_W'(WINDOW - 1)) begin
                            // A mismatch on the last bit already failed the
                            // threshold test above, so closing is safe here.
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt + WC_W'(1);
                            win_err <= win_err + WE_W'(mismatch);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end

            // A clear coinciding with a counted event keeps that event.
            if (chk.clear) begin
                chk.err_count <= CNT_W'(cnt_err);
                chk.bit_count <= CNT_W'(cnt_bit);
            end else begin
                if (cnt_err && (chk.err_count != {CNT_W{1'b1}}))
                    chk.err_count <= chk.err_count + CNT_W'(1);
                if (cnt_bit && (chk.bit_count != {CNT_W{1'b1}}))
                    chk.bit_count <= chk.bit_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_prbs12_checker.sv
module tb_prbs12_checker;
    localparam int LOCK_MATCHES = 24;
    localparam int WINDOW       = 64;
    localparam int UNLOCK_ERRS  = 8;
    localparam int CNT_W        = 16;
    localparam int CMAX         = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    prbs12_checker_if #(.CNT_W(CNT_W)) ifc ();

    prbs12_checker #(
        .LOCK_MATCHES (LOCK_MATCHES),
        .WINDOW       (WINDOW),
        .UNLOCK_ERRS  (UNLOCK_ERRS),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .chk   (ifc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    bit hist[$];
    bit m_locked, m_err, m_lost, m_zero;
    int m_run, m_wbits, m_werrs, m_errcnt, m_bitcnt;

    task automatic model_step(input bit r, input bit v, input bit b, input bit c);
        bit was_full, pred, mis, zero_now, cb, ce;
        int ones;
        m_err = 0; m_lost = 0; cb = 0; ce = 0;
        if (r) begin
            hist.delete();
            m_locked = 0; m_zero = 0; m_run = 0; m_wbits = 0; m_werrs = 0;
            m_errcnt = 0; m_bitcnt = 0;
            return;
        end
        if (v) begin
            was_full = (hist.size() == 12);
            // oldest element is h[11], newest h[0]
            pred = was_full ? (hist[0] ^ hist[3] ^ hist[6] ^ hist[11]) : 1'b0;
            mis  = (b != pred);
            hist.push_back(b);
            if (hist.size() > 12) void'(hist.pop_front());
            ones = 0;
            foreach (hist[i]) ones += int'(hist[i]);
            zero_now = (hist.size() == 12) && (ones == 0);
            if (hist.size() == 12) m_zero = zero_now;
            if (was_full && !m_locked) begin
                m_run = (mis || zero_now) ? 0 : m_run + 1;
                if (m_run == LOCK_MATCHES) begin
                    m_locked = 1; m_run = 0; m_wbits = 0; m_werrs = 0;
                end
            end else if (m_locked) begin
                cb = 1; ce = mis; m_err = mis;
                m_wbits++;
                m_werrs += int'(mis);
                if (m_werrs >= UNLOCK_ERRS || zero_now) begin
                    m_locked = 0; m_lost = 1; m_run = 0;
                end else if (m_wbits == WINDOW) begin
                    m_wbits = 0; m_werrs = 0;
                end
            end
        end
        if (c) begin
            m_errcnt = int'(ce);
            m_bitcnt = int'(cb);
        end else begin
            if (ce && m_errcnt < CMAX) m_errcnt++;
            if (cb && m_bitcnt < CMAX) m_bitcnt++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_vec();
        return 64'({ifc.locked, ifc.bit_err, ifc.lock_lost, ifc.zero_stuck,
                    ifc.err_count, ifc.bit_count});
    endfunction

    function automatic logic [63:0] mdl_vec();
        return 64'({m_locked, m_err, m_lost, m_zero,
                    CNT_W'(m_errcnt), CNT_W'(m_bitcnt)});
    endfunction

    task automatic apply(input bit r, input bit v, input bit b, input bit c);
        reset         = r;
        ifc.bit_valid = v;
        ifc.bit_in    = b;
        ifc.clear     = c;
        @(posedge clk);
        #1;
        model_step(r, v, b, c);
        check("model", dut_vec(), mdl_vec());
    endtask

    // lfsr1 generator: new LSB = s[11]^s[8]^s[5]^s[0], shifted in at the bottom
    logic [11:0] g;
    task automatic gen_bit(output bit nb);
        nb = g[11] ^ g[8] ^ g[5] ^ g[0];
        g  = {g[10:0], nb};
    endtask

    typedef struct {
        bit rst; bit v; bit b; bit clr;
        bit e_locked; bit e_zero; int e_errs; int e_bits;
    } vec_t;

    vec_t tbl[202];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bit nb, v, b, lost;
        int nv;
        logic [19:0] seen;

        ifc.bit_in = 0; ifc.bit_valid = 0; ifc.clear = 0;
        m_locked = 0; m_err = 0; m_lost = 0; m_zero = 0;
        m_run = 0; m_wbits = 0; m_werrs = 0; m_errcnt = 0; m_bitcnt = 0;

        // ---- table: reset, then an all-zero stream, then a lone clear ----
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 1; i <= 200; i++)
            tbl[i] = '{0, 1, 0, 0, 0, (i >= 12), 0, 0};
        tbl[201] = '{0, 0, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 202; i++) begin
            apply(tbl[i].rst, tbl[i].v, tbl[i].b, tbl[i].clr);
            check($sformatf("table[%0d]", i),
                  64'({ifc.locked, ifc.zero_stuck, ifc.err_count, ifc.bit_count}),
                  64'({tbl[i].e_locked, tbl[i].e_zero,
                       CNT_W'(tbl[i].e_errs), CNT_W'(tbl[i].e_bits)}));
        end

        // ---- clean stream: lock latency and bit counting ----
        apply(1, 0, 0, 0);
        g = 12'h001;
        for (int i = 1; i <= 36; i++) begin
            gen_bit(nb);
            apply(0, 1, nb, 0);
            if (i == 35) check("lock_before_36", 64'(ifc.locked), 64'(0));
        end
        check("lock_at_36", 64'(ifc.locked), 64'(1));
        for (int i = 0; i < 100; i++) begin
            gen_bit(nb);
            apply(0, 1, nb, 0);
        end
        check("bit_count_100", 64'(ifc.bit_count), 64'(100));
        check("err_count_clean", 64'(ifc.err_count), 64'(0));

        // ---- single flipped bit: five error pulses ----
        seen = '0;
        for (int j = 0; j < 20; j++) begin
            gen_bit(nb);
            apply(0, 1, (j == 0) ? !nb : nb, 0);
            if (ifc.bit_err) seen[j] = 1'b1;
        end
        check("err_offsets", 64'(seen), 64'(20'h01243));
        check("err_count_5", 64'(ifc.err_count), 64'(5));
        check("locked_after_flip", 64'(ifc.locked), 64'(1));

        // ---- align to a fresh window, clear, then random data ----
        for (int k = 0; k < 200 && (m_bitcnt % WINDOW) != 0; k++) begin
            gen_bit(nb);
            apply(0, 1, nb, 0);
        end
        apply(0, 0, 0, 1);
        lost = 0;
        for (int j = 0; j < WINDOW && !lost; j++) begin
            apply(0, 1, 1'($urandom_range(0, 1)), 0);
            lost = ifc.lock_lost;
        end
        check("lock_lost_seen", 64'(lost), 64'(1));
        check("err_count_at_loss", 64'(ifc.err_count), 64'(UNLOCK_ERRS));
        check("unlocked_after_loss", 64'(ifc.locked), 64'(0));

        // ---- gapped clean stream, reset mid-lock, clear with a flip ----
        apply(1, 0, 0, 0);
        g = 12'h001;
        nv = 0;
        for (int cyc = 0; cyc < 400 && nv < 36; cyc++) begin
            v = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (v) begin
                gen_bit(nb);
                b = nb;
            end
            apply(0, v, b, 0);
            if (v) begin
                nv++;
                if (nv == 35) check("gap_lock_before_36", 64'(ifc.locked), 64'(0));
            end
        end
        check("gap_lock_at_36", 64'(ifc.locked), 64'(1));
        for (int k = 0; k < 20; k++) begin
            v = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            if (v) begin
                gen_bit(nb);
                b = nb;
            end
            apply(0, v, b, 0);
        end
        apply(1, 1, 1, 1);
        check("reset_outputs", dut_vec(), 64'(0));

        g = 12'h001;
        for (int i = 1; i <= 36; i++) begin
            gen_bit(nb);
            apply(0, 1, nb, 0);
        end
        check("relock_at_36", 64'(ifc.locked), 64'(1));
        for (int i = 0; i < 5; i++) begin
            gen_bit(nb);
            apply(0, 1, nb, 0);
        end
        gen_bit(nb);
        apply(0, 1, !nb, 1);
        check("clear_with_err", 64'(ifc.err_count), 64'(1));
        check("clear_with_bit", 64'(ifc.bit_count), 64'(1));
        for (int i = 0; i < 12; i++) begin
            gen_bit(nb);
            apply(0, 1, nb, 0);
        end
        check("err_after_clear", 64'(ifc.err_count), 64'(5));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
